// File: rtl/exe_divider_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
interface exe_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             DivStartE;
   logic             DivSignedE;
   logic             DivRemE;
   logic [WIDTH-1:0] RD1E;
   logic [WIDTH-1:0] RD2E;
   logic             flush;
   logic             DivStallE;
   logic             DivDoneE;
   logic [WIDTH-1:0] DivResultE;

   modport master (
      output DivStartE, DivSignedE, DivRemE, RD1E, RD2E, flush,
      input  DivStallE, DivDoneE, DivResultE
   );

   modport slave (
      input  DivStartE, DivSignedE, DivRemE, RD1E, RD2E, flush,
      output DivStallE, DivDoneE, DivResultE
   );
endinterface

// File: rtl/exe_divider.sv
// Iterative restoring divider for the execute stage: one quotient bit per cycle,
// signed operation via magnitude division plus a sign fix-up on entry to DONE.
module exe_divider #(
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   exe_divider_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             sel_rem_q, sel_rem_d;

   logic             start_ok;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   trial, diff;
   logic [WIDTH-1:0] r_mag;

   assign start_ok = bus.DivStartE & ~bus.flush;
   assign a_neg    = bus.DivSignedE & bus.RD1E[WIDTH-1];
   assign b_neg    = bus.DivSignedE & bus.RD2E[WIDTH-1];
   assign a_abs    = a_neg ? (~bus.RD1E + 1'b1) : bus.RD1E;
   assign b_abs    = b_neg ? (~bus.RD2E + 1'b1) : bus.RD2E;

   // The dividend is shifted out of the quotient register MSB-first.
   assign trial = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign diff  = trial - {1'b0, dvs_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prem_d    = prem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      res_d     = res_q;
      qsign_d   = qsign_q;
      rsign_d   = rsign_q;
      sel_rem_d = sel_rem_q;
      r_mag     = '0;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               quo_d     = a_abs;
               dvs_d     = b_abs;
               prem_d    = '0;
               qsign_d   = a_neg ^ b_neg;
               rsign_d   = a_neg;
               sel_rem_d = bus.DivRemE;
               if (bus.RD2E == '0) begin
                  // Divide by zero bypasses the iteration entirely.
                  state_d = StDone;
                  res_d   = bus.DivRemE ? bus.RD1E : '1;
               end else begin
                  state_d = StBusy;
                  cnt_d   = CntInit;
               end
            end
         end
         StBusy: begin
            prem_d = diff[WIDTH] ? trial : diff;
            quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDone;
               r_mag   = prem_d[WIDTH-1:0];
               if (sel_rem_q) res_d = rsign_q ? (~r_mag + 1'b1) : r_mag;
               else           res_d = qsign_q ? (~quo_d + 1'b1) : quo_d;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (bus.flush) begin
         state_d = StIdle;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         prem_q    <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         res_q     <= '0;
         qsign_q   <= 1'b0;
         rsign_q   <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prem_q    <= prem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         res_q     <= res_d;
         qsign_q   <= qsign_d;
         rsign_q   <= rsign_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   assign bus.DivStallE  = ~rst & (((state_q == StIdle) & start_ok) | (state_q == StBusy));
   assign bus.DivDoneE   = ~rst & (state_q == StDone) & ~bus.flush;
   assign bus.DivResultE = res_q;

endmodule
